id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//   ID->EX pipeline register feeding the EX-stage ALU (20-bit one-hot alu_control, src1, src2).
//   Resolves RAW hazards by forwarding from EX/MEM/WB at capture time, selects immediate or
//   shift-amount operands, and applies valid/ready backpressure, load-use stall and flush.
//   Sits between decode and ALU; out_alu_* connect directly to the ALU inputs.
// PARAMETERS
//   DATA_W  32  operand/result width
//   CTRL_W  20  alu_control width (one-hot: bit0 add .. bit19 bneq)
//   RA_W    5   register address width
// PORTS
//   clk              in   1        clock; all state updates on posedge
//   resetn           in   1        asynchronous, active-low reset
//   in_valid         in   1        decode holds a valid instruction
//   in_ready         out  1        stage will accept in_* this cycle
//   in_alu_control   in   CTRL_W   one-hot ALU op from decode
//   in_rs_addr       in   RA_W     source 1 register number
//   in_rt_addr       in   RA_W     source 2 register number
//   in_rs_val        in   DATA_W   register-file value for rs
//   in_rt_val        in   DATA_W   register-file value for rt
//   in_imm           in   DATA_W   immediate, already sign/zero-extended by decode
//   in_src1_is_sa    in   1        src1 = {27'b0, in_imm[10:6]} (sll/srl/sra)
//   in_src2_is_imm   in   1        src2 = in_imm
//   in_dest          in   RA_W     destination register (0 = none)
//   in_pc            in   DATA_W   instruction PC
//   flush            in   1        kill held and incoming instruction
//   ex_fwd_valid/addr/data   in 1/RA_W/DATA_W  producer leaving EX this cycle (ALU result)
//   ex_fwd_pending   in   1        EX producer's data not ready (load); blocks forwarding
//   mem_fwd_valid/addr/data  in 1/RA_W/DATA_W  producer in MEM
//   wb_fwd_valid/addr/data   in 1/RA_W/DATA_W  producer in WB
//   out_valid        out  1        ALU inputs hold a valid instruction
//   out_ready        in   1        downstream consumes this cycle
//   out_alu_control  out  CTRL_W   to ALU; forced 0 when out_valid=0
//   out_alu_src1     out  DATA_W   to ALU src1
//   out_alu_src2     out  DATA_W   to ALU src2
//   out_store_data   out  DATA_W   forwarded rt value (for stores)
//   out_dest/out_pc  out  RA_W/DATA_W  carried through
// BEHAVIOUR
//   Reset (resetn=0, async): out_valid=0, all registered fields 0; out_alu_control reads 0.
//   Single-entry register; latency 1 cycle from accept to out_valid.
//   hazard = in_valid & ex_fwd_valid & ex_fwd_pending & ex_fwd_addr!=0 &
//            (ex_fwd_addr==in_rs_addr&~in_src1_is_sa | ex_fwd_addr==in_rt_addr).
//   in_ready = (~out_valid | out_ready) & ~hazard. accept = in_valid & in_ready.
//   Forward per source, priority EX > MEM > WB > register file; a source matches only if
//     its valid=1, addr==reg, addr!=0; EX match suppressed while ex_fwd_pending.
//   src1 = in_src1_is_sa ? {27'b0,in_imm[10:6]} : fwd_rs; src2 = in_src2_is_imm ? in_imm : fwd_rt;
//   out_store_data = fwd_rt regardless of in_src2_is_imm. All selected at capture only;
//   held contents never re-forwarded (older producers are downstream and already sampled).
//   Next-state per edge, in priority order:
//     flush            -> out_valid<=0 (drop held and incoming; fields don't-care)
//     accept           -> load all fields, out_valid<=1
//     out_valid&out_ready&~accept -> out_valid<=0 (bubble)
//     else             -> hold (stall: all outputs stable)
//   Simultaneous consume+accept: back-to-back, no bubble. hazard with empty stage: bubble
//   inserted (out_valid=0) until ex_fwd_pending drops. Address 0 never forwarded (reads 0
//   from regfile). Non-one-hot in_alu_control passed through unchanged (decode's duty).
//   Reset asserted mid-stall clears out_valid immediately; no partial state survives.
// TESTING
//   1 reset, then in_valid=1, add, rs_val=5, rt_val=7, out_ready=1 -> next cycle out_valid=1,
//     ctrl=20'h00001, src1=5, src2=7; resetn=0 mid-hold -> out_valid=0, out_alu_control=0.
//   2 rs=3, ex_fwd(3,0x11), mem_fwd(3,0x22), wb_fwd(3,0x33) -> src1=0x11; drop ex -> 0x22;
//     drop mem -> 0x33; rs=0 with all fwd addr=0 -> src1=in_rs_val (0).
//   3 sll, in_imm[10:6]=4, src1_is_sa=1, rt fwd from MEM 0x80 -> src1=4, src2=0x80.
//   4 ex_fwd_pending=1, addr=rt -> in_ready=0, out_valid=0 next cycle; pending drops with
//     mem_fwd(rt,0xAB) -> accepted, src2=0xAB.
//   5 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; flush=1 with
//     in_valid=1 -> out_valid=0 next cycle, incoming not loaded.
//   6 stream 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles, no bubbles.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side and ALU-side handshake bundle for the ID->EX operand stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 20,
  parameter int RA_W   = 5
);
  // decode -> stage
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_alu_control;
  logic [RA_W-1:0]   in_rs_addr;
  logic [RA_W-1:0]   in_rt_addr;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic [DATA_W-1:0] in_imm;
  logic              in_src1_is_sa;
  logic              in_src2_is_imm;
  logic [RA_W-1:0]   in_dest;
  logic [DATA_W-1:0] in_pc;

  // stage -> ALU
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_alu_control;
  logic [DATA_W-1:0] out_alu_src1;
  logic [DATA_W-1:0] out_alu_src2;
  logic [DATA_W-1:0] out_store_data;
  logic [RA_W-1:0]   out_dest;
  logic [DATA_W-1:0] out_pc;

  // the pipeline stage itself
  modport slave (
    input  in_valid, in_alu_control, in_rs_addr, in_rt_addr, in_rs_val, in_rt_val,
           in_imm, in_src1_is_sa, in_src2_is_imm, in_dest, in_pc, out_ready,
    output in_ready, out_valid, out_alu_control, out_alu_src1, out_alu_src2,
           out_store_data, out_dest, out_pc
  );

  // the surrounding pipeline (decode + ALU)
  modport master (
    output in_valid, in_alu_control, in_rs_addr, in_rt_addr, in_rs_val, in_rt_val,
           in_imm, in_src1_is_sa, in_src2_is_imm, in_dest, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_control, out_alu_src1, out_alu_src2,
           out_store_data, out_dest, out_pc
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: forwards operands at capture, selects imm/shamt,
// and applies valid/ready backpressure, load-use stall and flush.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 20,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              ex_fwd_valid,
  input  logic              ex_fwd_pending,
  input  logic [RA_W-1:0]   ex_fwd_addr,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              mem_fwd_valid,
  input  logic [RA_W-1:0]   mem_fwd_addr,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [RA_W-1:0]   wb_fwd_addr,
  input  logic [DATA_W-1:0] wb_fwd_data,
  id_ex_operand_stage_if.slave bus
);

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] src1_q,  src1_d;
  logic [DATA_W-1:0] src2_q,  src2_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [RA_W-1:0]   dest_q,  dest_d;
  logic [DATA_W-1:0] pc_q,    pc_d;

  logic              hazard;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] sa_val;

  // Youngest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [RA_W-1:0]   addr,
                                                input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] r;
    r = rf_val;
    if (addr != '0) begin
      if (ex_fwd_valid && !ex_fwd_pending && ex_fwd_addr == addr)
        r = ex_fwd_data;
      else if (mem_fwd_valid && mem_fwd_addr == addr)
        r = mem_fwd_data;
      else if (wb_fwd_valid && wb_fwd_addr == addr)
        r = wb_fwd_data;
    end
    return r;
  endfunction

  // Load-use hazard detection, handshake and operand selection.
  always_comb begin
    hazard = bus.in_valid && ex_fwd_valid && ex_fwd_pending && (ex_fwd_addr != '0) &&
             (((ex_fwd_addr == bus.in_rs_addr) && !bus.in_src1_is_sa) ||
              (ex_fwd_addr == bus.in_rt_addr));
    in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    accept   = bus.in_valid && in_ready;
    fwd_rs   = fwd_sel(bus.in_rs_addr, bus.in_rs_val);
    fwd_rt   = fwd_sel(bus.in_rt_addr, bus.in_rt_val);
    sa_val   = {{(DATA_W-5){1'b0}}, bus.in_imm[10:6]};
  end

  // Next-state: flush beats accept beats consume-only bubble beats hold.
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    store_d     = store_q;
    dest_d      = dest_q;
    pc_d        = pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = bus.in_alu_control;
      src1_d      = bus.in_src1_is_sa  ? sa_val     : fwd_rs;
      src2_d      = bus.in_src2_is_imm ? bus.in_imm : fwd_rt;
      store_d     = fwd_rt;
      dest_d      = bus.in_dest;
      pc_d        = bus.in_pc;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      store_q     <= '0;
      dest_q      <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      store_q     <= store_d;
      dest_q      <= dest_d;
      pc_q        <= pc_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_alu_control = out_valid_q ? ctrl_q : '0;
  assign bus.out_alu_src1    = src1_q;
  assign bus.out_alu_src2    = src2_q;
  assign bus.out_store_data  = store_q;
  assign bus.out_dest        = dest_q;
  assign bus.out_pc          = pc_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected packets are modelled at
// handshake time and compared when the ALU side consumes them.
module tb_id_ex_operand_stage;

  typedef struct {
    logic [19:0] ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store;
    logic [4:0]  dest;
    logic [31:0] pc;
  } pkt_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        ex_v, ex_p, mem_v, wb_v;
  logic [4:0]  ex_a, mem_a, wb_a;
  logic [31:0] ex_d, mem_d, wb_d;

  pkt_t        sb_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  id_ex_operand_stage_if #(.DATA_W(32), .CTRL_W(20), .RA_W(5)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .CTRL_W(20), .RA_W(5)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .ex_fwd_valid   (ex_v),
    .ex_fwd_pending (ex_p),
    .ex_fwd_addr    (ex_a),
    .ex_fwd_data    (ex_d),
    .mem_fwd_valid  (mem_v),
    .mem_fwd_addr   (mem_a),
    .mem_fwd_data   (mem_d),
    .wb_fwd_valid   (wb_v),
    .wb_fwd_addr    (wb_a),
    .wb_fwd_data    (wb_d),
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0)                          return rf;
    if (ex_v && !ex_p && ex_a == a)         return ex_d;
    if (mem_v && mem_a == a)                return mem_d;
    if (wb_v && wb_a == a)                  return wb_d;
    return rf;
  endfunction

  function automatic pkt_t ref_pkt();
    pkt_t p;
    logic [31:0] rs_f, rt_f;
    rs_f    = ref_fwd(bus.in_rs_addr, bus.in_rs_val);
    rt_f    = ref_fwd(bus.in_rt_addr, bus.in_rt_val);
    p.ctrl  = bus.in_alu_control;
    p.src1  = bus.in_src1_is_sa ? {27'd0, bus.in_imm[10:6]} : rs_f;
    p.src2  = bus.in_src2_is_imm ? bus.in_imm : rt_f;
    p.store = rt_f;
    p.dest  = bus.in_dest;
    p.pc    = bus.in_pc;
    return p;
  endfunction

  // Compare on consumption first, then record what is being accepted.
  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        pkt_t e;
        e = sb_q.pop_front();
        chk("sb_ctrl",  32'(bus.out_alu_control), 32'(e.ctrl));
        chk("sb_src1",  bus.out_alu_src1,   e.src1);
        chk("sb_src2",  bus.out_alu_src2,   e.src2);
        chk("sb_store", bus.out_store_data, e.store);
        chk("sb_dest",  32'(bus.out_dest),  32'(e.dest));
        chk("sb_pc",    bus.out_pc,         e.pc);
      end
    end
    if (resetn && bus.in_valid && bus.in_ready && !flush)
      sb_q.push_back(ref_pkt());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_idle();
    ex_v = 0; ex_p = 0; ex_a = 0; ex_d = 0;
    mem_v = 0; mem_a = 0; mem_d = 0;
    wb_v = 0; wb_a = 0; wb_d = 0;
  endtask

  task automatic drive(input logic [19:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                       input logic sa, input logic isimm, input logic [4:0] dest,
                       input logic [31:0] pc);
    bus.in_valid       = 1'b1;
    bus.in_alu_control = c;
    bus.in_rs_addr     = rs;
    bus.in_rt_addr     = rt;
    bus.in_rs_val      = rsv;
    bus.in_rt_val      = rtv;
    bus.in_imm         = imm;
    bus.in_src1_is_sa  = sa;
    bus.in_src2_is_imm = isimm;
    bus.in_dest        = dest;
    bus.in_pc          = pc;
  endtask

  // Send one instruction, check src1 directly, then let it drain.
  task automatic fwd_case(input string tag, input logic [31:0] exp_src1);
    drive(20'h00001, 5'd3, 5'd9, 32'hDEAD, 32'h99, 32'h0, 1'b0, 1'b0, 5'd7, 32'h300);
    step();
    bus.in_valid = 1'b0;
    chk(tag, bus.out_alu_src1, exp_src1);
    step();
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; fwd_idle();
    bus.out_ready = 1'b0;
    drive(20'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    step(); step();

    // reset state
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ctrl",  32'(bus.out_alu_control), 32'd0);
    chk("rst_src1",  bus.out_alu_src1, 32'd0);
    chk("rst_src2",  bus.out_alu_src2, 32'd0);
    chk("rst_store", bus.out_store_data, 32'd0);
    chk("rst_dest",  32'(bus.out_dest), 32'd0);
    chk("rst_pc",    bus.out_pc, 32'd0);
    resetn = 1'b1;
    step();

    // basic add, one-cycle latency
    bus.out_ready = 1'b1;
    drive(20'h00001, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 5'd4, 32'h100);
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_ctrl",  32'(bus.out_alu_control), 32'h00001);
    chk("t1_src1",  bus.out_alu_src1, 32'd5);
    chk("t1_src2",  bus.out_alu_src2, 32'd7);
    step();
    chk("t1_drained", 32'(bus.out_valid), 32'd0);

    // reset asserted while holding
    bus.out_ready = 1'b0;
    drive(20'h00002, 5'd1, 5'd2, 32'd8, 32'd9, 32'h0, 1'b0, 1'b0, 5'd4, 32'h104);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("t1_held", 32'(bus.out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t1_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_rst_ctrl",  32'(bus.out_alu_control), 32'd0);
    chk("t1_rst_src1",  bus.out_alu_src1, 32'd0);
    sb_q.delete();
    step();
    resetn = 1'b1;
    step();

    // forwarding priority
    bus.out_ready = 1'b1;
    ex_v = 1; ex_a = 5'd3; ex_d = 32'h11;
    mem_v = 1; mem_a = 5'd3; mem_d = 32'h22;
    wb_v = 1; wb_a = 5'd3; wb_d = 32'h33;
    fwd_case("t2_ex", 32'h11);
    ex_v = 0;
    fwd_case("t2_mem", 32'h22);
    mem_v = 0;
    fwd_case("t2_wb", 32'h33);
    wb_v = 0;
    fwd_case("t2_rf", 32'hDEAD);
    ex_v = 1; ex_a = 0; ex_d = 32'h44;
    mem_v = 1; mem_a = 0; mem_d = 32'h55;
    wb_v = 1; wb_a = 0; wb_d = 32'h66;
    drive(20'h00001, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd7, 32'h310);
    step();
    bus.in_valid = 1'b0;
    chk("t2_r0_src1", bus.out_alu_src1, 32'h0);
    chk("t2_r0_src2", bus.out_alu_src2, 32'h0);
    step();
    fwd_idle();

    // shift amount as src1, rt forwarded from MEM
    ex_v = 1; ex_a = 5'd3; ex_d = 32'h77;
    mem_v = 1; mem_a = 5'd5; mem_d = 32'h80;
    drive(20'h00400, 5'd3, 5'd5, 32'h1, 32'h2, 32'h0000_0100, 1'b1, 1'b0, 5'd8, 32'h400);
    step();
    bus.in_valid = 1'b0;
    chk("t3_src1", bus.out_alu_src1, 32'd4);
    chk("t3_src2", bus.out_alu_src2, 32'h80);
    step();
    fwd_idle();

    // load-use stall
    ex_v = 1; ex_p = 1; ex_a = 5'd6; ex_d = 32'hEE;
    drive(20'h00001, 5'd1, 5'd6, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 5'd9, 32'h500);
    #1;
    chk("t4_ready_lo", 32'(bus.in_ready), 32'd0);
    step();
    chk("t4_bubble", 32'(bus.out_valid), 32'd0);
    ex_v = 0; ex_p = 0;
    mem_v = 1; mem_a = 5'd6; mem_d = 32'hAB;
    #1;
    chk("t4_ready_hi", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t4_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_src2",  bus.out_alu_src2, 32'hAB);
    step();
    fwd_idle();

    // backpressure hold then flush
    bus.out_ready = 1'b0;
    drive(20'h00010, 5'd1, 5'd2, 32'h123, 32'h456, 32'h0, 1'b0, 1'b0, 5'd10, 32'h600);
    step();
    drive(20'h00020, 5'd1, 5'd2, 32'hBAD, 32'hBAD, 32'h0, 1'b0, 1'b0, 5'd11, 32'h604);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t5_hold_src1",  bus.out_alu_src1, 32'h123);
      chk("t5_hold_pc",    bus.out_pc, 32'h600);
      chk("t5_ready_lo",   32'(bus.in_ready), 32'd0);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_held", 32'(bus.out_valid), 32'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_flush_in", 32'(bus.out_valid), 32'd0);
    step();

    // back-to-back stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(20'h00001 << i, 5'd1, 5'd2, 32'(i + 10), 32'(i + 20), 32'h0, 1'b0, 1'b0,
            5'(i + 1), 32'(32'h700 + 4 * i));
      step();
      chk("t6_valid", 32'(bus.out_valid), 32'd1);
      chk("t6_pc",    bus.out_pc, 32'(32'h700 + 4 * i));
    end
    bus.in_valid = 1'b0;
    step();
    chk("t6_end", 32'(bus.out_valid), 32'd0);
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
